// File: rtl/divider_pkg.sv
// Shared widths and FSM state encoding for the 13-bit by 8-bit restoring divider.
package divider_pkg;

   localparam int unsigned N_W   = 13;             // dividend / quotient width, iteration count
   localparam int unsigned D_W   = 8;              // divisor / remainder width
   localparam int unsigned A_W   = 5;              // narrow-quotient width used by the overflow flag
   localparam int unsigned CNT_W = $clog2(N_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   p_in     : partial remainder (D_W+1 bits)
//   q_in     : quotient / dividend shift register (N_W bits)
//   divisor  : divisor (D_W bits)
//   p_next   : partial remainder after shift and trial subtract/restore
//   q_next   : shift register with the new quotient bit in bit 0
module div_step
   import divider_pkg::*;
(
   input  logic [D_W:0]   p_in,
   input  logic [N_W-1:0] q_in,
   input  logic [D_W-1:0] divisor,
   output logic [D_W:0]   p_next,
   output logic [N_W-1:0] q_next
);

   logic [D_W+1:0] shifted;
   logic           fits;

   // {P,Q} << 1: the dividend MSB moves into the partial remainder.
   assign shifted = {p_in, q_in[N_W-1]};
   // Trial subtract succeeds when the shifted remainder is at least the divisor.
   assign fits    = (shifted >= {2'b00, divisor});

   always_comb begin
      p_next = shifted[D_W:0];
      q_next = {q_in[N_W-2:0], 1'b0};
      if (fits) begin
         p_next = shifted[D_W:0] - {1'b0, divisor};
         q_next = {q_in[N_W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divider_13bits_8bits.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// valid/ready handshake on both sides. dividend = q_num*b_num + r_num.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (dividend, b_num)
//   out_valid/out_ready : result handshake (q_num, r_num, dz_flag, ovf_flag)
//   dz_flag             : divisor was zero (q_num all ones, r_num zero)
//   ovf_flag            : quotient does not fit in A_W bits
module divider_13bits_8bits
   import divider_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] b_num,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_W-1:0] q_num,
   output logic [D_W-1:0] r_num,
   output logic           dz_flag,
   output logic           ovf_flag
);

   state_t         state,     state_nxt;
   logic [D_W:0]   p_reg,     p_nxt;
   logic [N_W-1:0] q_reg,     q_nxt;
   logic [D_W-1:0] d_reg,     d_nxt;
   logic [CNT_W-1:0] cnt,     cnt_nxt;
   logic [N_W-1:0] q_num_nxt;
   logic [D_W-1:0] r_num_nxt;
   logic           dz_nxt;
   logic           ovf_nxt;

   logic [D_W:0]   step_p;
   logic [N_W-1:0] step_q;

   div_step u_step (
      .p_in    (p_reg),
      .q_in    (q_reg),
      .divisor (d_reg),
      .p_next  (step_p),
      .q_next  (step_q)
   );

   // Next-state, datapath and result logic.
   always_comb begin
      state_nxt = state;
      p_nxt     = p_reg;
      q_nxt     = q_reg;
      d_nxt     = d_reg;
      cnt_nxt   = cnt;
      q_num_nxt = q_num;
      r_num_nxt = r_num;
      dz_nxt    = dz_flag;
      ovf_nxt   = ovf_flag;

      unique case (state)
         ST_IDLE: begin
            if (in_valid) begin
               q_nxt   = dividend;
               d_nxt   = b_num;
               p_nxt   = '0;
               cnt_nxt = '0;
               if (b_num == '0) begin
                  // Divide-by-zero short-circuits straight to the result.
                  state_nxt = ST_DONE;
                  q_num_nxt = '1;
                  r_num_nxt = '0;
                  dz_nxt    = 1'b1;
                  ovf_nxt   = 1'b1;
               end else begin
                  state_nxt = ST_CALC;
               end
            end
         end

         ST_CALC: begin
            p_nxt   = step_p;
            q_nxt   = step_q;
            cnt_nxt = cnt + CNT_W'(1);
            // Last iteration: publish the result straight from the step output.
            if (cnt == CNT_W'(N_W - 1)) begin
               state_nxt = ST_DONE;
               q_num_nxt = step_q;
               r_num_nxt = step_p[D_W-1:0];
               dz_nxt    = 1'b0;
               ovf_nxt   = |step_q[N_W-1:A_W];
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and registered outputs; handshake flags track the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         cnt       <= '0;
         q_num     <= '0;
         r_num     <= '0;
         dz_flag   <= 1'b0;
         ovf_flag  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         p_reg     <= p_nxt;
         q_reg     <= q_nxt;
         d_reg     <= d_nxt;
         cnt       <= cnt_nxt;
         q_num     <= q_num_nxt;
         r_num     <= r_num_nxt;
         dz_flag   <= dz_nxt;
         ovf_flag  <= ovf_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         out_valid <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_divider_13bits_8bits.sv
// Self-checking bench for divider_13bits_8bits: directed vector table,
// back-pressure, mid-operation reset and multiplier loopback sequences.
module tb_divider_13bits_8bits;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] dividend;
   logic [7:0]  b_num;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] q_num;
   logic [7:0]  r_num;
   logic        dz_flag;
   logic        ovf_flag;

   int checks = 0;
   int errors = 0;

   divider_13bits_8bits dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .b_num     (b_num),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q_num     (q_num),
      .r_num     (r_num),
      .dz_flag   (dz_flag),
      .ovf_flag  (ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [12:0] dvd;
      logic [7:0]  dvs;
      logic [12:0] q;
      logic [7:0]  r;
      logic        dz;
      logic        ovf;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Wait for in_ready, present operands for one accept edge, then scramble inputs.
   task automatic start_op(input logic [12:0] dvd, input logic [7:0] dvs);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      dividend = dvd;
      b_num    = dvs;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 13'($urandom);
      b_num    = 8'($urandom);
   endtask

   // Edges counted from the accept edge (inclusive) until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [12:0] dvd, input logic [7:0] dvs,
                        output logic [12:0] q, output logic [7:0] r,
                        output logic dz, output logic ovf, output int lat);
      start_op(dvd, dvs);
      wait_valid(lat);
      q   = q_num;
      r   = r_num;
      dz  = dz_flag;
      ovf = ovf_flag;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t        vecs[10];
      logic [12:0] q;
      logic [7:0]  r;
      logic        dz, ovf;
      int          lat;
      logic [12:0] hq;
      logic [7:0]  hr;
      logic        hdz, hovf;

      // {dividend, divisor, q, r, dz, ovf, latency}
      vecs[0] = '{13'd100,  8'd7,   13'd14,   8'd2,   1'b0, 1'b0, 14};
      vecs[1] = '{13'd7905, 8'd255, 13'd31,   8'd0,   1'b0, 1'b0, 14};
      vecs[2] = '{13'd8191, 8'd1,   13'd8191, 8'd0,   1'b0, 1'b1, 14};
      vecs[3] = '{13'd1234, 8'd0,   13'd8191, 8'd0,   1'b1, 1'b1, 1};
      vecs[4] = '{13'd50,   8'd5,   13'd10,   8'd0,   1'b0, 1'b0, 14};
      vecs[5] = '{13'd32,   8'd1,   13'd32,   8'd0,   1'b0, 1'b1, 14};
      vecs[6] = '{13'd31,   8'd1,   13'd31,   8'd0,   1'b0, 1'b0, 14};
      vecs[7] = '{13'd0,    8'd3,   13'd0,    8'd0,   1'b0, 1'b0, 14};
      vecs[8] = '{13'd8191, 8'd255, 13'd32,   8'd31,  1'b0, 1'b1, 14};
      vecs[9] = '{13'd254,  8'd255, 13'd0,    8'd254, 1'b0, 1'b0, 14};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      b_num     = '0;
      #22;
      chk("rst_in_ready",  int'(in_ready),  1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_q",         int'(q_num),     0);
      chk("rst_r",         int'(r_num),     0);
      chk("rst_dz",        int'(dz_flag),   0);
      chk("rst_ovf",       int'(ovf_flag),  0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].dvd, vecs[i].dvs, q, r, dz, ovf, lat);
         chk($sformatf("vec%0d_q", i),   int'(q),   int'(vecs[i].q));
         chk($sformatf("vec%0d_r", i),   int'(r),   int'(vecs[i].r));
         chk($sformatf("vec%0d_dz", i),  int'(dz),  int'(vecs[i].dz));
         chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
         chk($sformatf("vec%0d_lat", i), lat,       vecs[i].lat);
         chk($sformatf("vec%0d_idle", i), int'(in_ready), 1);
      end

      // Back-pressure: result held, input side blocked, in_valid pulses ignored.
      start_op(13'd100, 8'd7);
      wait_valid(lat);
      chk("bp_lat", lat, 14);
      hq = q_num; hr = r_num; hdz = dz_flag; hovf = ovf_flag;
      chk("bp_q", int'(hq), 14);
      chk("bp_r", int'(hr), 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = c[0];
         dividend = 13'd5;
         b_num    = 8'd1;
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_valid", c), int'(out_valid), 1);
         chk($sformatf("bp%0d_ready", c), int'(in_ready),  0);
         chk($sformatf("bp%0d_q", c),     int'(q_num),     int'(hq));
         chk($sformatf("bp%0d_r", c),     int'(r_num),     int'(hr));
         chk($sformatf("bp%0d_flags", c), int'({dz_flag, ovf_flag}), int'({hdz, hovf}));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_release_ready", int'(in_ready),  1);
      chk("bp_release_valid", int'(out_valid), 0);

      // Reset during CALC iteration 6 abandons the operation.
      start_op(13'd8191, 8'd1);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", int'(out_valid), 0);
      chk("mrst_in_ready",  int'(in_ready),  1);
      chk("mrst_q",         int'(q_num),     0);
      chk("mrst_r",         int'(r_num),     0);
      chk("mrst_flags",     int'({dz_flag, ovf_flag}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(13'd50, 8'd5, q, r, dz, ovf, lat);
      chk("post_rst_q",   int'(q),   10);
      chk("post_rst_r",   int'(r),   0);
      chk("post_rst_lat", lat,       14);

      // Multiplier loopback: (A*B)/B must return A with zero remainder.
      for (int t = 0; t < 2000; t++) begin
         int unsigned a, b;
         logic [12:0] prod;
         a = $urandom_range(31, 0);
         b = $urandom_range(255, 1);
         prod = 13'(a * b);
         do_op(prod, 8'(b), q, r, dz, ovf, lat);
         if ({q, r, dz, ovf} != {13'(a), 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL loop%0d %0d/%0d: got q=%0d r=%0d dz=%0d ovf=%0d expected q=%0d r=0 dz=0 ovf=0",
                     t, prod, b, q, r, dz, ovf, a);
         end
         checks++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
